comparater_ctrl: RTL and testbench

Sequencing controller for the 1-bit button comparator in the lab-1 design. It synchronises and debounces the two raw push-buttons and drives the settled values into the comparator. It then samples the comparator's three result lines one cycle later and shows the registered result on the LEDs for a fixed hold window. It also counts completed comparisons and flags any result from the comparator that is not one-hot.

---
 rtl/comparater_ctrl_if.sv | 19 +
 rtl/comparater_ctrl.sv | 146 ++++++++++++++
 tb/tb_comparater_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparater_ctrl_if.sv
// Bus between the sequencing controller and the 1-bit comparator:
// operands flow out of the controller and the three result lines flow back.
interface comparater_ctrl_if;
  logic cmp_a;
  logic cmp_b;
  logic cmp_less;
  logic cmp_equal;
  logic cmp_greater;

  modport master (
    output cmp_a, cmp_b,
    input  cmp_less, cmp_equal, cmp_greater
  );

  modport slave (
    input  cmp_a, cmp_b,
    output cmp_less, cmp_equal, cmp_greater
  );
endinterface

// File: rtl/comparater_ctrl.sv
// Button comparator sequencer: synchronise and debounce the buttons, drive the
// comparator, then capture its one-hot result on the LEDs for a hold window.
module comparater_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             button1,
  input  logic             button2,
  comparater_ctrl_if.master cmp,
  output logic             led_less,
  output logic             led_equal,
  output logic             led_greater,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cmp_count,
  output logic             err
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, APPLY, SAMPLE, HOLD} state_t;

  state_t state, next_state;

  logic [1:0]        start_sync;
  logic              start_prev;
  logic [1:0]        btn_meta;
  logic [1:0]        btn_sync;
  logic [1:0]        cand;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_edge;
  logic              result_onehot;

  logic load_cand, db_inc, latch_ops, do_sample, hold_inc, hold_exit;

  assign start_edge    = start_sync[1] & ~start_prev;
  assign result_onehot = ({cmp.cmp_less, cmp.cmp_equal, cmp.cmp_greater} inside {3'b100, 3'b010, 3'b001});
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A button change while settling always wins over the stable-count exit.
  always_comb begin
    next_state = state;
    load_cand  = 1'b0;
    db_inc     = 1'b0;
    latch_ops  = 1'b0;
    do_sample  = 1'b0;
    hold_inc   = 1'b0;
    hold_exit  = 1'b0;
    case (state)
      IDLE: begin
        load_cand = 1'b1;
        if (start_edge) next_state = SETTLE;
      end
      SETTLE: begin
        if (btn_sync != cand) begin
          load_cand = 1'b1;
        end else if (db_cnt == DB_LAST) begin
          latch_ops  = 1'b1;
          next_state = APPLY;
        end else begin
          db_inc = 1'b1;
        end
      end
      APPLY:  next_state = SAMPLE;
      SAMPLE: begin
        do_sample  = 1'b1;
        next_state = HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_exit  = 1'b1;
          next_state = IDLE;
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync  <= '0;
      start_prev  <= 1'b0;
      btn_meta    <= '0;
      btn_sync    <= '0;
      cand        <= '0;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      cmp.cmp_a   <= 1'b0;
      cmp.cmp_b   <= 1'b0;
      led_less    <= 1'b0;
      led_equal   <= 1'b0;
      led_greater <= 1'b0;
      done        <= 1'b0;
      cmp_count   <= '0;
      err         <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], start};
      start_prev <= start_sync[1];
      btn_meta   <= {button1, button2};
      btn_sync   <= btn_meta;
      done       <= do_sample;

      if (load_cand) begin
        cand   <= btn_sync;
        db_cnt <= '0;
      end else if (db_inc) begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (latch_ops) {cmp.cmp_a, cmp.cmp_b} <= cand;

      if (do_sample) begin
        led_less    <= cmp.cmp_less;
        led_equal   <= cmp.cmp_equal;
        led_greater <= cmp.cmp_greater;
        cmp_count   <= cmp_count + 1'b1;
        hold_cnt    <= '0;
        if (!result_onehot) err <= 1'b1;
      end else if (hold_inc) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if (hold_exit) begin
        led_less    <= 1'b0;
        led_equal   <= 1'b0;
        led_greater <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comparater_ctrl.sv
// Self-checking bench for comparater_ctrl with a stub comparator and a
// timeline model that predicts every output per cycle from the button activity.
module tb_comparater_ctrl;
  localparam int D  = 4;
  localparam int H  = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic button1 = 1'b0;
  logic button2 = 1'b0;
  logic force_bad = 1'b0;
  logic led_less, led_equal, led_greater, busy, done, err;
  logic [CW-1:0] cmp_count;

  int checks = 0;
  int errors = 0;

  int exp_count = 0;
  bit exp_err = 1'b0;
  bit prev_a = 1'b0;
  bit prev_b = 1'b0;

  comparater_ctrl_if cif();

  // Stub comparator; force_bad makes it report both less and greater.
  assign cif.cmp_less    = force_bad ? 1'b1 : (~cif.cmp_a &  cif.cmp_b);
  assign cif.cmp_equal   = force_bad ? 1'b0 : ~(cif.cmp_a ^ cif.cmp_b);
  assign cif.cmp_greater = force_bad ? 1'b1 : ( cif.cmp_a & ~cif.cmp_b);

  comparater_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .button1(button1), .button2(button2),
    .cmp(cif.master),
    .led_less(led_less), .led_equal(led_equal), .led_greater(led_greater),
    .busy(busy), .done(done), .cmp_count(cmp_count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_count = 0;
    exp_err   = 1'b0;
    prev_a    = 1'b0;
    prev_b    = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    repeat (2) tick();
  endtask

  // One full comparison. c>0 toggles button2 so the new value is first sampled
  // c edges after E0; the accepted value then needs D more stable cycles.
  task automatic run_compare(input bit b1, input bit b2, input bit bad, input int c,
                             input bit hold_pulse, input string tag);
    int latch_k, samp_k, end_k;
    bit fb2;
    bit [2:0] trip;
    bit [CW-1:0] cnt_before, cnt_after;
    bit err_after;
    button1 = b1;
    button2 = b2;
    force_bad = bad;
    start = 1'b0;
    repeat (3) tick();
    fb2 = (c > 0) ? ~b2 : b2;
    latch_k = 2 + D + c;
    samp_k = latch_k + 2;
    end_k = samp_k + H;
    trip = bad ? 3'b101 : {(!b1 && fb2), (b1 == fb2), (b1 && !fb2)};
    cnt_before = CW'(exp_count);
    cnt_after = CW'((exp_count + 1) % (1 << CW));
    err_after = exp_err | bad;
    start = 1'b1;
    tick();
    for (int k = 0; k <= end_k + 2; k++) begin
      bit e_busy, e_done, e_err;
      bit [1:0] e_ab;
      bit [2:0] e_led;
      bit [CW-1:0] e_cnt;
      e_busy = (k >= 2) && (k < end_k);
      e_done = (k == samp_k);
      e_ab   = (k >= latch_k) ? {b1, fb2} : {prev_a, prev_b};
      e_led  = ((k >= samp_k) && (k < end_k)) ? trip : 3'b000;
      e_cnt  = (k >= samp_k) ? cnt_after : cnt_before;
      e_err  = (k >= samp_k) ? err_after : exp_err;
      checks += 6;
      if (busy !== e_busy) begin
        errors++;
        $display("[TB] FAIL %s busy k=%0d got %b expected %b", tag, k, busy, e_busy);
      end
      if (done !== e_done) begin
        errors++;
        $display("[TB] FAIL %s done k=%0d got %b expected %b", tag, k, done, e_done);
      end
      if ({cif.cmp_a, cif.cmp_b} !== e_ab) begin
        errors++;
        $display("[TB] FAIL %s cmp_ab k=%0d got %b expected %b", tag, k, {cif.cmp_a, cif.cmp_b}, e_ab);
      end
      if ({led_less, led_equal, led_greater} !== e_led) begin
        errors++;
        $display("[TB] FAIL %s leds k=%0d got %b expected %b", tag, k, {led_less, led_equal, led_greater}, e_led);
      end
      if (cmp_count !== e_cnt) begin
        errors++;
        $display("[TB] FAIL %s cmp_count k=%0d got %0d expected %0d", tag, k, cmp_count, e_cnt);
      end
      if (err !== e_err) begin
        errors++;
        $display("[TB] FAIL %s err k=%0d got %b expected %b", tag, k, err, e_err);
      end
      if (k == 1) start = 1'b0;
      if (c > 0 && k == c - 1) button2 = fb2;
      if (hold_pulse && k == samp_k + 1) start = 1'b1;
      if (hold_pulse && k == samp_k + 3) start = 1'b0;
      tick();
    end
    prev_a = b1;
    prev_b = fb2;
    exp_count = (exp_count + 1) % (1 << CW);
    exp_err = err_after;
    force_bad = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'($urandom);
    button1 = 1'($urandom);
    button2 = 1'($urandom);
    force_bad = 1'($urandom);
    tick();
    tick();
    checks++;
    if ({cif.cmp_a, cif.cmp_b, led_less, led_equal, led_greater, busy, done, err} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset outputs got %b expected 0",
               {cif.cmp_a, cif.cmp_b, led_less, led_equal, led_greater, busy, done, err});
    end
    checks++;
    if (cmp_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset cmp_count got %0d expected 0", cmp_count);
    end
    rst = 1'b0;
    start = 1'b0;
    force_bad = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle busy got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    run_compare(1'b0, 1'b1, 1'b0, 0, 1'b0, "basic_less");
    run_compare(1'b1, 1'b1, 1'b0, 0, 1'b0, "basic_equal");
    run_compare(1'b1, 1'b0, 1'b0, 0, 1'b0, "basic_greater");
  endtask

  task automatic test_bounce();
    run_compare(1'b0, 1'b0, 1'b0, 4, 1'b0, "bounce_e4");
    run_compare(1'b1, 1'b1, 1'b0, 1, 1'b0, "bounce_e1");
    run_compare(1'b1, 1'b0, 1'b0, D, 1'b0, "bounce_last");
  endtask

  task automatic test_start_in_hold();
    run_compare(1'b0, 1'b1, 1'b0, 0, 1'b1, "start_in_hold");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_compare(1'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, D)),
                  1'($urandom), "random");
    end
  endtask

  task automatic test_wrap();
    bit [CW-1:0] seq [4];
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_compare(1'($urandom), 1'($urandom), 1'b0, 0, 1'b0, "wrap");
      checks++;
      if (cmp_count !== seq[i]) begin
        errors++;
        $display("[TB] FAIL wrap_seq[%0d] got %0d expected %0d", i, cmp_count, seq[i]);
      end
    end
  endtask

  task automatic test_err();
    run_compare(1'b1, 1'b0, 1'b1, 0, 1'b0, "err_bad");
    run_compare(1'b0, 1'b0, 1'b0, 0, 1'b0, "err_sticky");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_held got %b expected 1", err);
    end
  endtask

  // Reset lands mid-SETTLE; it must abort the comparison and clear err.
  task automatic test_abort();
    button1 = 1'b1;
    button2 = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre busy got %b expected 1", busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({cif.cmp_a, cif.cmp_b, led_less, led_equal, led_greater, busy, done, err} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL abort outputs got %b expected 0",
               {cif.cmp_a, cif.cmp_b, led_less, led_equal, led_greater, busy, done, err});
    end
    checks++;
    if (cmp_count !== '0) begin
      errors++;
      $display("[TB] FAIL abort cmp_count got %0d expected 0", cmp_count);
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({done, busy, cmp_count} !== '0) begin
        errors++;
        $display("[TB] FAIL abort_after k=%0d got done=%b busy=%b cnt=%0d expected 0",
                 k, done, busy, cmp_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_start_in_hold();
    test_random();
    test_wrap();
    test_err();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
